// File: rtl/data_memory_bytelane.sv
// Little-endian byte-lane data memory; the async reset clears every word and all outputs.
// Loads have a 1-cycle registered latency and are accepted every cycle, with no backpressure.
module data_memory_bytelane #(
    parameter int DEPTH_WORDS = 256,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  ReadValid,
    output logic                  AddrError
);
    localparam int AW = $clog2(DEPTH_WORDS);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("data_memory_bytelane: DATA_WIDTH must be 32");
    end
    if (DEPTH_WORDS < 4 || DEPTH_WORDS > 65536 ||
        (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("data_memory_bytelane: DEPTH_WORDS must be a power of two in 4..65536");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_vld;
    logic                  r_err;

    logic [AW-1:0]         w_idx;
    logic                  w_err;
    logic                  w_we;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdat;
    logic [DATA_WIDTH-1:0] w_word;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_ld;

    assign w_idx = Address[AW+1:2];

    // Any address bit above the word index means >= 4*DEPTH_WORDS, so nothing aliases.
    assign w_err = (|Address[31:AW+2])
                 || (Size == 2'b11)
                 || (Size == 2'b01 && Address[0])
                 || (Size == 2'b10 && Address[1:0] != 2'b00);

    assign w_we = MemWrite && !w_err;

    always_comb begin
        w_be   = 4'b0000;
        w_wdat = WriteData;
        case (Size)
            2'b00: begin
                w_be   = 4'b0001 << Address[1:0];
                w_wdat = {4{WriteData[7:0]}};
            end
            2'b01: begin
                w_be   = Address[1] ? 4'b1100 : 4'b0011;
                w_wdat = {2{WriteData[15:0]}};
            end
            2'b10: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_comb begin
        w_word = r_mem[w_idx];
        w_byte = w_word[7:0];
        case (Address[1:0])
            2'b00: w_byte = w_word[7:0];
            2'b01: w_byte = w_word[15:8];
            2'b10: w_byte = w_word[23:16];
            2'b11: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
        w_half = Address[1] ? w_word[31:16] : w_word[15:0];
        case (Size)
            2'b00:   w_ld = {{24{~Unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_ld = {{16{~Unsigned & w_half[15]}}, w_half};
            default: w_ld = w_word;
        endcase
    end

    // The load path reads w_word before this edge commits, which gives read-before-write.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (w_we && w_be[l]) begin
                    r_mem[w_idx][8*l +: 8] <= w_wdat[8*l +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_rdata <= '0;
            r_vld   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_vld <= MemRead;
            r_err <= (MemRead || MemWrite) && w_err;
            if (MemRead) begin
                r_rdata <= w_err ? '0 : w_ld;
            end
        end
    end

    assign ReadData  = r_rdata;
    assign ReadValid = r_vld;
    assign AddrError = r_err;
endmodule

// File: tb/tb_data_memory_bytelane.sv
// Directed-vector bench for data_memory_bytelane with hand-computed expectations.
module tb_data_memory_bytelane;
    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic        AddrError;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    data_memory_bytelane #(.DEPTH_WORDS(256), .DATA_WIDTH(32)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Size      (Size),
        .Unsigned  (Unsigned),
        .ReadData  (ReadData),
        .ReadValid (ReadValid),
        .AddrError (AddrError)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request for one edge, then go idle; outputs are sampled 1 ns after the edge.
    task automatic op(input logic wr, input logic rd, input logic [31:0] addr,
                      input logic [31:0] wdat, input logic [1:0] sz, input logic uns);
        @(negedge CLK);
        MemWrite  = wr;
        MemRead   = rd;
        Address   = addr;
        WriteData = wdat;
        Size      = sz;
        Unsigned  = uns;
        @(posedge CLK);
        #1;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
    endtask

    task automatic expect_load(input string tag, input logic [31:0] data, input logic err);
        check({tag, ".vld"}, {31'b0, ReadValid}, 32'd1);
        check({tag, ".err"}, {31'b0, AddrError}, {31'b0, err});
        check({tag, ".dat"}, ReadData, data);
    endtask

    task automatic expect_store(input string tag, input logic err);
        check({tag, ".vld"}, {31'b0, ReadValid}, 32'd0);
        check({tag, ".err"}, {31'b0, AddrError}, {31'b0, err});
    endtask

    initial begin
        Reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
        Address = '0; WriteData = '0; Size = SZ_W; Unsigned = 1'b0;
        #1;
        check("rst.dat", ReadData, 32'h0);
        check("rst.vld", {31'b0, ReadValid}, 32'd0);
        check("rst.err", {31'b0, AddrError}, 32'd0);
        // Requests during reset must be ignored.
        op(1'b1, 1'b1, 32'h0, 32'hDEADBEEF, SZ_W, 1'b0);
        check("rst_req.vld", {31'b0, ReadValid}, 32'd0);
        check("rst_req.dat", ReadData, 32'h0);
        @(negedge CLK);
        Reset = 1'b0;

        op(1'b0, 1'b1, 32'h0, 32'h0, SZ_W, 1'b0);
        expect_load("ld0_after_rst", 32'h0, 1'b0);

        op(1'b1, 1'b0, 32'h0, 32'd170, SZ_W, 1'b0);
        expect_store("st0", 1'b0);
        op(1'b1, 1'b0, 32'h4, 32'd80, SZ_W, 1'b0);
        expect_store("st4", 1'b0);
        op(1'b0, 1'b1, 32'h0, 32'h0, SZ_W, 1'b0);
        expect_load("ld0", 32'd170, 1'b0);
        op(1'b0, 1'b1, 32'h4, 32'h0, SZ_W, 1'b0);
        expect_load("ld4", 32'd80, 1'b0);
        op(1'b0, 1'b0, 32'h0, 32'h0, SZ_W, 1'b0);
        check("idle.vld", {31'b0, ReadValid}, 32'd0);
        check("idle.hold", ReadData, 32'd80);

        op(1'b1, 1'b0, 32'h5, 32'hFFFFFFAB, SZ_B, 1'b0);
        expect_store("stb5", 1'b0);
        op(1'b0, 1'b1, 32'h4, 32'h0, SZ_W, 1'b0);
        expect_load("ld4_b", 32'h0000AB50, 1'b0);
        op(1'b0, 1'b1, 32'h5, 32'h0, SZ_B, 1'b0);
        expect_load("ldb5_s", 32'hFFFFFFAB, 1'b0);
        op(1'b0, 1'b1, 32'h5, 32'h0, SZ_B, 1'b1);
        expect_load("ldb5_u", 32'h000000AB, 1'b0);
        op(1'b0, 1'b1, 32'h4, 32'h0, SZ_B, 1'b0);
        expect_load("ldb4_s", 32'h00000050, 1'b0);

        op(1'b1, 1'b0, 32'h2, 32'h00008001, SZ_H, 1'b0);
        expect_store("sth2", 1'b0);
        op(1'b0, 1'b1, 32'h2, 32'h0, SZ_H, 1'b0);
        expect_load("ldh2_s", 32'hFFFF8001, 1'b0);
        op(1'b0, 1'b1, 32'h2, 32'h0, SZ_H, 1'b1);
        expect_load("ldh2_u", 32'h00008001, 1'b0);
        op(1'b0, 1'b1, 32'h0, 32'h0, SZ_W, 1'b0);
        expect_load("ld0_h", 32'h800100AA, 1'b0);

        op(1'b0, 1'b1, 32'h2, 32'h0, SZ_W, 1'b0);
        expect_load("ldw_mis", 32'h0, 1'b1);
        op(1'b1, 1'b0, 32'h7, 32'h0000FFFF, SZ_H, 1'b0);
        expect_store("sth_mis", 1'b1);
        op(1'b1, 1'b0, 32'h400, 32'h55555555, SZ_W, 1'b0);
        expect_store("stw_oor", 1'b1);
        op(1'b1, 1'b0, 32'h0, 32'h77777777, SZ_R, 1'b0);
        expect_store("st_rsv", 1'b1);
        op(1'b0, 1'b0, 32'h0, 32'h0, SZ_W, 1'b0);
        check("err_pulse_end", {31'b0, AddrError}, 32'd0);
        op(1'b0, 1'b1, 32'h0, 32'h0, SZ_W, 1'b0);
        expect_load("ld0_unchanged", 32'h800100AA, 1'b0);
        op(1'b0, 1'b1, 32'h400, 32'h0, SZ_W, 1'b0);
        expect_load("ld_oor", 32'h0, 1'b1);
        op(1'b0, 1'b1, 32'h4, 32'h0, SZ_W, 1'b0);
        expect_load("ld4_unchanged", 32'h0000AB50, 1'b0);

        op(1'b1, 1'b1, 32'h8, 32'h12345678, SZ_W, 1'b0);
        expect_load("rbw_old", 32'h0, 1'b0);
        op(1'b0, 1'b1, 32'h8, 32'h0, SZ_W, 1'b0);
        expect_load("rbw_new", 32'h12345678, 1'b0);

        op(1'b1, 1'b1, 32'h401, 32'h0, SZ_W, 1'b0);
        expect_load("both_err", 32'h0, 1'b1);
        op(1'b0, 1'b0, 32'h0, 32'h0, SZ_W, 1'b0);
        check("both_err_once", {31'b0, AddrError}, 32'd0);

        // Reset lands between a sampled-to-be load and its edge.
        @(negedge CLK);
        MemRead = 1'b1; Address = 32'h8; Size = SZ_W;
        #2;
        Reset = 1'b1;
        #1;
        check("mid_rst.vld", {31'b0, ReadValid}, 32'd0);
        check("mid_rst.dat", ReadData, 32'h0);
        check("mid_rst.err", {31'b0, AddrError}, 32'd0);
        @(posedge CLK);
        #1;
        MemRead = 1'b0;
        check("mid_rst_edge.vld", {31'b0, ReadValid}, 32'd0);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        check("post_rst.vld", {31'b0, ReadValid}, 32'd0);
        op(1'b0, 1'b1, 32'h8, 32'h0, SZ_W, 1'b0);
        expect_load("post_rst_ld8", 32'h0, 1'b0);
        op(1'b0, 1'b1, 32'h0, 32'h0, SZ_W, 1'b0);
        expect_load("post_rst_ld0", 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
